vga_scan_timing: RTL

- Generates the 640x480@60 VGA raster that drives the sprite renderer.
- Produces pixel coordinates x/y, which the renderer consumes and returns as a 3-bit rgb value.
- Registers that rgb together with hsync/vsync and blanking so that colour and sync leave the FPGA aligned.
- Also emits frame and generation ticks that pace the Game of Life update engine.

---
 rtl/vga_scan_timing.sv | 87 ++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480@60 raster counters, registered sync/blank/colour stage,
// frame and generation pacing ticks for the Game of Life engine.
module vga_scan_timing #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit SYNC_POL       = 1'b0,
    parameter int CE_DIV         = 1,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_ce,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       frame_tick,
    output logic       gen_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [3:0] r_div;
    logic [9:0] r_x, r_y;
    logic [7:0] r_gen;
    logic       r_ce, r_hs, r_vs, r_ft, r_gt;
    logic [2:0] r_rgb;
    logic       w_hend, w_vend, w_wrap, w_hs_on, w_vs_on, w_gen_end;

    assign w_hend    = r_x == 10'(H_TOTAL - 1);
    assign w_vend    = r_y == 10'(V_TOTAL - 1);
    assign w_wrap    = r_ce && w_hend && w_vend;
    assign w_hs_on   = r_x >= 10'(H_ACTIVE + H_FP) && r_x < 10'(H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_on   = r_y >= 10'(V_ACTIVE + V_FP) && r_y < 10'(V_ACTIVE + V_FP + V_SYNC);
    assign w_gen_end = r_gen == 8'(FRAMES_PER_GEN - 1);

    assign x          = r_x;
    assign y          = r_y;
    assign pix_ce     = r_ce;
    assign active     = r_x < 10'(H_ACTIVE) && r_y < 10'(V_ACTIVE);
    assign hsync      = r_hs;
    assign vsync      = r_vs;
    assign rgb        = r_rgb;
    assign frame_tick = r_ft;
    assign gen_tick   = r_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_ce  <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_gen <= '0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
            r_rgb <= '0;
            r_ft  <= 1'b0;
            r_gt  <= 1'b0;
        end else begin
            // pix_ce is registered so it is low straight out of reset, even for CE_DIV=1
            r_div <= r_div == 4'(CE_DIV - 1) ? 4'd0 : r_div + 4'd1;
            r_ce  <= r_div == 4'(CE_DIV - 1);
            r_ft  <= w_wrap;
            r_gt  <= w_wrap && run && w_gen_end;
            if (w_wrap && run)
                r_gen <= w_gen_end ? 8'd0 : r_gen + 8'd1;
            if (r_ce) begin
                r_x <= w_hend ? 10'd0 : r_x + 10'd1;
                if (w_hend)
                    r_y <= w_vend ? 10'd0 : r_y + 10'd1;
                r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
                r_rgb <= active ? rgb_in : 3'b000;
            end
        end
    end
endmodule
